xres_reset_sequencer: RTL and testbench

Clocked controller that sits behind the XRES reset pad in the chip's management area. It sequences the pad's enable controls in the required power-up and power-down order, synchronizes and glitch-filters the pad's XRES_H_N output, and releases a two-stage reset (core, then peripherals) with programmable hold times. It also accepts a software reset request, a power-down request, and a VCCHIB-mode select.

---
 rtl/xres_reset_sequencer.sv | 168 ++++++++++++++++
 tb/tb_xres_reset_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/xres_reset_sequencer.sv
// XRES pad reset sequencer: orders the pad enables on power-up/down, filters XRES_H_N
// and releases core then peripheral reset after programmable hold times.
module xres_reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8,
  parameter int HOLD_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              xres_h_n,
  input  logic [FILT_W-1:0] filt_len,
  input  logic [HOLD_W-1:0] hold_len,
  input  logic              sw_reset,
  input  logic              pwr_down,
  input  logic              mode_vcchib,
  output logic              pad_enable_vddio,
  output logic              pad_enable_h,
  output logic              pad_en_vddio_sig_h,
  output logic              pad_inp_sel_h,
  output logic              pad_disable_pullup_h,
  output logic              core_rst,
  output logic              periph_rst,
  output logic              xres_event,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    PWRUP    = 3'd0,
    PAD_ON   = 3'd1,
    ASSERTED = 3'd2,
    RELEASE1 = 3'd3,
    RELEASE2 = 3'd4,
    RUN      = 3'd5,
    PD_H     = 3'd6,
    OFF      = 3'd7
  } state_t;

  state_t cur, nxt;

  logic [SYNC_STAGES-1:0] sync;
  logic                   xs;
  logic                   filt;
  logic [FILT_W-1:0]      fc;
  logic [HOLD_W-1:0]      hc, nxt_hc;
  logic                   rst_req;
  logic nxt_vddio, nxt_en_h, nxt_sig, nxt_pullup, nxt_core, nxt_periph, nxt_event;

  assign xs            = sync[SYNC_STAGES-1];
  assign state         = cur;
  assign pad_inp_sel_h = 1'b0;
  assign rst_req       = !filt || sw_reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync <= '0;
      filt <= 1'b0;
      fc   <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], xres_h_n};
      if (xs == filt) begin
        fc <= '0;
      end else if (fc == filt_len) begin
        filt <= xs;
        fc   <= '0;
      end else begin
        fc <= fc + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur                  <= PWRUP;
      hc                   <= '0;
      pad_enable_vddio     <= 1'b0;
      pad_enable_h         <= 1'b0;
      pad_en_vddio_sig_h   <= 1'b1;
      pad_disable_pullup_h <= 1'b0;
      core_rst             <= 1'b1;
      periph_rst           <= 1'b1;
      xres_event           <= 1'b0;
    end else begin
      cur                  <= nxt;
      hc                   <= nxt_hc;
      pad_enable_vddio     <= nxt_vddio;
      pad_enable_h         <= nxt_en_h;
      pad_en_vddio_sig_h   <= nxt_sig;
      pad_disable_pullup_h <= nxt_pullup;
      core_rst             <= nxt_core;
      periph_rst           <= nxt_periph;
      xres_event           <= nxt_event;
    end
  end

  always_comb begin
    nxt        = cur;
    nxt_hc     = hc;
    nxt_vddio  = pad_enable_vddio;
    nxt_en_h   = pad_enable_h;
    nxt_sig    = pad_en_vddio_sig_h;
    nxt_core   = core_rst;
    nxt_periph = periph_rst;
    nxt_event  = 1'b0;

    if (pwr_down && cur == PWRUP) begin
      nxt = OFF;
    end else if (pwr_down && cur != PD_H && cur != OFF) begin
      // ENABLE_H drops on PD_H entry so it always leads ENABLE_VDDIO down
      nxt      = PD_H;
      nxt_en_h = 1'b0;
    end else if (rst_req && (cur == RELEASE1 || cur == RELEASE2 || cur == RUN)) begin
      nxt       = ASSERTED;
      nxt_event = 1'b1;
    end else begin
      case (cur)
        PWRUP: begin
          nxt       = PAD_ON;
          nxt_vddio = 1'b1;
          nxt_sig   = ~mode_vcchib;
        end
        PAD_ON: begin
          nxt      = ASSERTED;
          nxt_en_h = 1'b1;
        end
        ASSERTED: begin
          if (!rst_req) begin
            nxt    = RELEASE1;
            nxt_hc = '0;
          end
        end
        RELEASE1: begin
          if (hc == hold_len) begin
            nxt      = RELEASE2;
            nxt_core = 1'b0;
            nxt_hc   = '0;
          end else begin
            nxt_hc = hc + 1'b1;
          end
        end
        RELEASE2: begin
          if (hc == hold_len) begin
            nxt        = RUN;
            nxt_periph = 1'b0;
            nxt_hc     = '0;
          end else begin
            nxt_hc = hc + 1'b1;
          end
        end
        RUN: nxt = RUN;
        PD_H: begin
          nxt       = OFF;
          nxt_vddio = 1'b0;
        end
        OFF: begin
          if (!pwr_down) nxt = PWRUP;
        end
        default: nxt = PWRUP;
      endcase
    end

    if (nxt == ASSERTED || nxt == PD_H || nxt == OFF) begin
      nxt_core   = 1'b1;
      nxt_periph = 1'b1;
    end
    nxt_pullup = (nxt == OFF);
  end

endmodule

// File: tb/tb_xres_reset_sequencer.sv
// Directed bench for xres_reset_sequencer: power-up order, glitch filter, sw reset,
// power-down, mode latch, plus a randomized run under continuous invariant checks.
module tb_xres_reset_sequencer;

  logic        clock, reset, xres_h_n, sw_reset, pwr_down, mode_vcchib;
  logic [7:0]  filt_len;
  logic [15:0] hold_len;
  logic        pad_enable_vddio, pad_enable_h, pad_en_vddio_sig_h, pad_inp_sel_h;
  logic        pad_disable_pullup_h, core_rst, periph_rst, xres_event;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  xres_reset_sequencer dut (
    .clock(clock), .reset(reset), .xres_h_n(xres_h_n), .filt_len(filt_len),
    .hold_len(hold_len), .sw_reset(sw_reset), .pwr_down(pwr_down),
    .mode_vcchib(mode_vcchib), .pad_enable_vddio(pad_enable_vddio),
    .pad_enable_h(pad_enable_h), .pad_en_vddio_sig_h(pad_en_vddio_sig_h),
    .pad_inp_sel_h(pad_inp_sel_h), .pad_disable_pullup_h(pad_disable_pullup_h),
    .core_rst(core_rst), .periph_rst(periph_rst), .xres_event(xres_event),
    .state(state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Structural invariants that must hold on every cycle, including during reset
  always @(negedge clock) begin
    total++;
    assert ((!pad_enable_h || pad_enable_vddio) &&
            (pad_disable_pullup_h === (state == 3'd7)) &&
            (core_rst || state == 3'd4 || state == 3'd5) &&
            (periph_rst || state == 3'd5) &&
            (pad_inp_sel_h === 1'b0)) else begin
      bad++;
      $error("[TB] FAIL invariant observed st=%0d h=%0b v=%0b pu=%0b c=%0b p=%0b expected ordered",
             state, pad_enable_h, pad_enable_vddio, pad_disable_pullup_h, core_rst, periph_rst);
    end
  end

  initial begin
    reset = 1'b1; xres_h_n = 1'b1; filt_len = 8'd3; hold_len = 16'd4;
    sw_reset = 1'b0; pwr_down = 1'b0; mode_vcchib = 1'b0;
    tick(2);
    check_output("rst_state", state, 0);
    check_output("rst_core", core_rst, 1);
    check_output("rst_periph", periph_rst, 1);
    check_output("rst_vddio", pad_enable_vddio, 0);
    check_output("rst_en_h", pad_enable_h, 0);
    check_output("rst_sig", pad_en_vddio_sig_h, 1);
    check_output("rst_pullup", pad_disable_pullup_h, 0);
    check_output("rst_event", xres_event, 0);

    // Power-up: edges counted from reset release
    reset = 1'b0;
    tick(1);
    check_output("pu1_state", state, 1);
    check_output("pu1_vddio", pad_enable_vddio, 1);
    check_output("pu1_en_h", pad_enable_h, 0);
    tick(1);
    check_output("pu2_state", state, 2);
    check_output("pu2_en_h", pad_enable_h, 1);
    check_output("pu2_sig", pad_en_vddio_sig_h, 1);
    tick(4);
    check_output("filt_wait_state", state, 2);
    tick(1);
    check_output("rel1_state", state, 3);
    tick(4);
    check_output("hold1_core", core_rst, 1);
    tick(1);
    check_output("core_fall", core_rst, 0);
    check_output("rel2_state", state, 4);
    check_output("rel2_periph", periph_rst, 1);
    tick(4);
    check_output("hold2_periph", periph_rst, 1);
    tick(1);
    check_output("periph_fall", periph_rst, 0);
    check_output("run_state", state, 5);

    // Three-cycle glitch is shorter than filt_len+1 and must be ignored
    xres_h_n = 1'b0;
    tick(3);
    xres_h_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check_output("glitch_event", xres_event, 0);
    end
    check_output("glitch_state", state, 5);

    // Four-cycle low: filt drops at the 6th edge, ASSERTED at the 7th
    xres_h_n = 1'b0;
    tick(4);
    xres_h_n = 1'b1;
    tick(2);
    check_output("pulse_pre_state", state, 5);
    check_output("pulse_pre_event", xres_event, 0);
    tick(1);
    check_output("pulse_state", state, 2);
    check_output("pulse_event", xres_event, 1);
    check_output("pulse_core", core_rst, 1);
    check_output("pulse_periph", periph_rst, 1);
    tick(1);
    check_output("pulse_event_clr", xres_event, 0);
    tick(2);
    check_output("refilt_state", state, 2);
    tick(1);
    check_output("rerel1_state", state, 3);
    tick(5);
    check_output("rerel2_state", state, 4);

    // One-cycle sw_reset midway through RELEASE2
    tick(1);
    sw_reset = 1'b1;
    tick(1);
    sw_reset = 1'b0;
    check_output("sw_state", state, 2);
    check_output("sw_event", xres_event, 1);
    check_output("sw_core", core_rst, 1);
    tick(1);
    check_output("sw_event_clr", xres_event, 0);
    check_output("sw_rel1", state, 3);
    tick(4);
    check_output("sw_hold_core", core_rst, 1);
    tick(1);
    check_output("sw_core_fall", core_rst, 0);
    tick(5);
    check_output("sw_run", state, 5);
    check_output("sw_periph", periph_rst, 0);

    // Power-down order, then power-up again with VCCHIB mode selected
    pwr_down = 1'b1;
    tick(1);
    check_output("pd_state", state, 6);
    check_output("pd_en_h", pad_enable_h, 0);
    check_output("pd_vddio", pad_enable_vddio, 1);
    check_output("pd_core", core_rst, 1);
    tick(1);
    check_output("off_state", state, 7);
    check_output("off_vddio", pad_enable_vddio, 0);
    check_output("off_pullup", pad_disable_pullup_h, 1);
    tick(1);
    check_output("off_hold", state, 7);
    mode_vcchib = 1'b1;
    pwr_down = 1'b0;
    tick(1);
    check_output("repu_state", state, 0);
    check_output("repu_pullup", pad_disable_pullup_h, 0);
    tick(1);
    check_output("repu_vddio", pad_enable_vddio, 1);
    check_output("repu_en_h", pad_enable_h, 0);
    check_output("mode_sig", pad_en_vddio_sig_h, 0);
    tick(1);
    check_output("repu_en_h2", pad_enable_h, 1);
    tick(1);
    check_output("repu_rel1", state, 3);
    tick(10);
    check_output("repu_run", state, 5);
    mode_vcchib = 1'b0;
    tick(2);
    check_output("mode_hold", pad_en_vddio_sig_h, 0);

    // pwr_down from PWRUP goes straight to OFF
    reset = 1'b1;
    pwr_down = 1'b1;
    tick(1);
    check_output("midrst_state", state, 0);
    check_output("midrst_sig", pad_en_vddio_sig_h, 1);
    check_output("midrst_vddio", pad_enable_vddio, 0);
    reset = 1'b0;
    tick(1);
    check_output("pwrup_off", state, 7);
    pwr_down = 1'b0;

    // Random traffic; the invariant block does the checking here
    filt_len = 8'd1;
    hold_len = 16'd2;
    for (int i = 0; i < 10000; i++) begin
      pwr_down = ($urandom_range(0, 39) == 0) ? ~pwr_down : pwr_down;
      xres_h_n = ($urandom_range(0, 7) == 0) ? ~xres_h_n : xres_h_n;
      sw_reset = ($urandom_range(0, 49) == 0);
      reset    = ($urandom_range(0, 199) == 0);
      mode_vcchib = $urandom_range(0, 1) == 1;
      tick(1);
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
